i2c_cmd_datapath: RTL and testbench

I2C_CMD_DATAPATH -- requirements
Module: i2c_cmd_datapath

---
 rtl/i2c_cmd_datapath_if.sv | 28 ++
 rtl/i2c_cmd_datapath.sv | 135 +++++++++++++
 tb/tb_i2c_cmd_datapath.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/i2c_cmd_datapath_if.sv
// i2c_cmd_datapath_if: command, response and bus-line bundle for the I2C command engine
//   slave  : engine side (takes commands and sampled lines, drives lines and responses)
//   master : issuer / bus side (offers commands, reads responses, feeds back sampled lines)
interface i2c_cmd_datapath_if #(parameter int PRESCALER_W = 8);
    logic [PRESCALER_W-1:0] prescaler_i;
    logic                   cmd_valid_i;
    logic [2:0]             cmd_i;
    logic [7:0]             cmd_data_i;
    logic                   cmd_ack_i;
    logic                   cmd_ready_o;
    logic                   scl_i;
    logic                   sda_i;
    logic                   scl_o;
    logic                   sda_o;
    logic                   rsp_valid_o;
    logic [7:0]             rsp_data_o;
    logic                   rsp_ack_o;
    logic                   rsp_err_o;
    logic                   busy_o;
    modport slave (
        input  prescaler_i, cmd_valid_i, cmd_i, cmd_data_i, cmd_ack_i, scl_i, sda_i,
        output cmd_ready_o, scl_o, sda_o, rsp_valid_o, rsp_data_o, rsp_ack_o, rsp_err_o, busy_o
    );
    modport master (
        output prescaler_i, cmd_valid_i, cmd_i, cmd_data_i, cmd_ack_i, scl_i, sda_i,
        input  cmd_ready_o, scl_o, sda_o, rsp_valid_o, rsp_data_o, rsp_ack_o, rsp_err_o, busy_o
    );
endinterface

// File: rtl/i2c_cmd_datapath.sv
// i2c_cmd_datapath: byte-level I2C master engine executing START/WRITE/READ/STOP/RSTART commands
//   i2c_core_clock_i : core clock, rising edge
//   reset_bit_n_i    : asynchronous active-low reset
//   bus              : command handshake, response and SCL/SDA lines (slave modport)
module i2c_cmd_datapath #(
    parameter int PRESCALER_W = 8,
    parameter bit STRETCH_EN  = 1'b1,
    parameter bit ARB_EN      = 1'b1
) (
    input logic               i2c_core_clock_i,
    input logic               reset_bit_n_i,
    i2c_cmd_datapath_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, RSTART, DATA, ACK, STOP, DONE} state_t;
    state_t state_q, state_d;
    logic [PRESCALER_W-1:0] cnt_q, cnt_d, p_q, p_d;
    logic [1:0] q_q, q_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d, rsp_data_q, rsp_data_d;
    logic rd_q, rd_d, ack_q, ack_d, pend_q, pend_d, busy_q, busy_d;
    logic scl_q, scl_d, sda_q, sda_d, rsp_ack_q, rsp_ack_d, rsp_err_q, rsp_err_d;
    logic ready, accept, stall, tick, sample, arb;

    assign ready  = (state_q == IDLE && !pend_q) || state_q == DONE;
    assign accept = bus.cmd_valid_i && ready;
    // a slave holding SCL low during the high phase freezes the quarter timer
    assign stall  = STRETCH_EN && q_q == 2'd2 && !bus.scl_i;
    assign tick   = !stall && cnt_q == p_q - 1'b1;
    assign sample = tick && q_q == 2'd2;

    always_comb begin
        state_d = state_q; cnt_d = cnt_q; p_d = p_q; q_d = q_q; bit_d = bit_q; sh_d = sh_q;
        rd_d = rd_q; ack_d = ack_q; pend_d = 1'b0; busy_d = busy_q;
        rsp_data_d = rsp_data_q; rsp_ack_d = rsp_ack_q; rsp_err_d = rsp_err_q;
        arb = 1'b0;
        if (state_q == IDLE || state_q == DONE) begin
            state_d = IDLE;
            if (pend_q) begin
                state_d = DONE;
                rsp_err_d = 1'b1;
            end else if (accept) begin
                cnt_d = '0; q_d = '0; bit_d = '0;
                p_d = (bus.prescaler_i == '0) ? PRESCALER_W'(1) : bus.prescaler_i;
                sh_d = bus.cmd_data_i; ack_d = bus.cmd_ack_i; rd_d = bus.cmd_i == 3'd2;
                case (bus.cmd_i)
                    3'd0: begin
                        state_d = busy_q ? RSTART : START;
                        busy_d = 1'b1;
                    end
                    3'd1, 3'd2: state_d = busy_q ? DATA : IDLE;
                    3'd3: state_d = busy_q ? STOP : IDLE;
                    3'd4: state_d = busy_q ? RSTART : IDLE;
                    default: state_d = IDLE;
                endcase
                // rejected commands spend one silent cycle before reporting
                pend_d = state_d == IDLE;
            end
        end else begin
            if (!stall) cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) q_d = q_q + 1'b1;
            // read bits and the slave's ACK after a write shift in at the sample point
            if (sample && ((state_q == DATA && rd_q) || (state_q == ACK && !rd_q))) sh_d = {sh_q[6:0], bus.sda_i};
            if (tick && q_q == 2'd3) begin
                bit_d = state_q == DATA ? bit_q + 1'b1 : bit_q;
                state_d = state_q == DATA ? ((bit_q == 3'd7) ? ACK : DATA) : DONE;
                if (state_q == DATA && !rd_q) sh_d = {sh_q[6:0], 1'b0};
                if (state_d == DONE) begin
                    rsp_err_d = 1'b0;
                    if (state_q == ACK && rd_q) rsp_data_d = sh_q;
                    if (state_q == ACK && !rd_q) rsp_ack_d = sh_q[0];
                    if (state_q == STOP) busy_d = 1'b0;
                end
            end
            if (ARB_EN && sample && state_q == DATA && !rd_q && sda_q && !bus.sda_i) begin
                arb = 1'b1;
                state_d = DONE;
                rsp_err_d = 1'b1;
                busy_d = 1'b0;
            end
        end
        // line levels follow the upcoming slot position; between commands they hold
        scl_d = scl_q; sda_d = sda_q;
        case (state_d)
            START: begin
                scl_d = 1'b1;
                sda_d = q_d < 2'd2;
            end
            RSTART: begin
                scl_d = q_d != 2'd0;
                sda_d = q_d < 2'd2;
            end
            STOP: begin
                scl_d = q_d[1];
                sda_d = q_d == 2'd3;
            end
            DATA: begin
                scl_d = q_d[1];
                if (rd_d) sda_d = 1'b1;
                else if (q_d != 2'd0) sda_d = sh_d[7];
            end
            ACK: begin
                scl_d = q_d[1];
                sda_d = rd_d ? ack_d : 1'b1;
            end
            default: ;
        endcase
        if (arb) begin
            scl_d = 1'b1;
            sda_d = 1'b1;
        end
    end

    always_ff @(posedge i2c_core_clock_i or negedge reset_bit_n_i) begin
        if (!reset_bit_n_i) begin
            state_q <= IDLE; cnt_q <= '0; p_q <= '0; q_q <= '0; bit_q <= '0; sh_q <= '0;
            rd_q <= 1'b0; ack_q <= 1'b0; pend_q <= 1'b0; busy_q <= 1'b0;
            scl_q <= 1'b1; sda_q <= 1'b1;
            rsp_data_q <= '0; rsp_ack_q <= 1'b1; rsp_err_q <= 1'b0;
        end else begin
            state_q <= state_d; cnt_q <= cnt_d; p_q <= p_d; q_q <= q_d; bit_q <= bit_d; sh_q <= sh_d;
            rd_q <= rd_d; ack_q <= ack_d; pend_q <= pend_d; busy_q <= busy_d;
            scl_q <= scl_d; sda_q <= sda_d;
            rsp_data_q <= rsp_data_d; rsp_ack_q <= rsp_ack_d; rsp_err_q <= rsp_err_d;
        end
    end

    assign bus.cmd_ready_o = ready;
    assign bus.scl_o       = scl_q;
    assign bus.sda_o       = sda_q;
    assign bus.rsp_valid_o = state_q == DONE;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.rsp_ack_o   = rsp_ack_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.busy_o      = busy_q;
endmodule

// File: tb/tb_i2c_cmd_datapath.sv
// tb_i2c_cmd_datapath: randomized command stream against a transaction-level model with a bus slave
module tb_i2c_cmd_datapath;
    localparam int PW = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic slave_sda = 1'b1;
    logic stretch = 1'b0;
    bit m_busy = 1'b0;
    int checks = 0;
    int errors = 0;

    i2c_cmd_datapath_if #(.PRESCALER_W(PW)) bus();
    i2c_cmd_datapath #(.PRESCALER_W(PW), .STRETCH_EN(1'b1), .ARB_EN(1'b1)) dut (
        .i2c_core_clock_i(clk),
        .reset_bit_n_i(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    assign bus.sda_i = bus.sda_o & slave_sda;
    assign bus.scl_i = bus.scl_o & ~stretch;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_lines"}, {bus.scl_o, bus.sda_o, bus.cmd_ready_o, bus.rsp_valid_o,
                               bus.busy_o, bus.rsp_err_o, bus.rsp_ack_o}, 7'b1110001);
        check({tag, "_data"}, bus.rsp_data_o, 0);
    endtask

    // cont: byte a competing master puts on SDA during a write; sbit: read slot to stretch (-1 none)
    task automatic do_cmd(input logic [2:0] cmd, input logic [7:0] d, input logic ack, input logic [7:0] presc,
                          input logic [7:0] rbyte, input logic [7:0] cont, input logic sack,
                          input int sbit, input int abort_fall);
        int p, n, fall, rise, stl, k, lat;
        bit legal, rd, wr, quiet, rdy_bad, rise_hi, fall_hi, aborted, nb;
        logic [8:0] cap;
        logic pscl, psda;
        p = (presc == 0) ? 1 : int'(presc);
        legal = cmd == 3'd0 || (m_busy && cmd >= 3'd1 && cmd <= 3'd4);
        rd = legal && cmd == 3'd2;
        wr = legal && cmd == 3'd1;
        @(negedge clk);
        check("ready_idle", bus.cmd_ready_o, 1);
        pscl = bus.scl_o; psda = bus.sda_o;
        bus.cmd_valid_i = 1'b1; bus.cmd_i = cmd; bus.cmd_data_i = d; bus.cmd_ack_i = ack; bus.prescaler_i = presc;
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0; bus.cmd_i = 3'($urandom); bus.cmd_data_i = 8'($urandom);
        bus.cmd_ack_i = 1'($urandom); bus.prescaler_i = 8'($urandom);
        fall = 0; rise = 0; stl = 0; cap = '0; quiet = 1; rdy_bad = 0; rise_hi = 0; fall_hi = 0; aborted = 0;
        for (n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (bus.scl_o != pscl || bus.sda_o != psda) quiet = 0;
            if (!bus.rsp_valid_o && bus.cmd_ready_o) rdy_bad = 1;
            if (pscl && !bus.scl_o) begin
                fall++;
                if (rd) slave_sda = (fall <= 8) ? rbyte[3'(8 - fall)] : 1'b1;
                else if (wr) slave_sda = (fall <= 8) ? cont[3'(8 - fall)] : ((fall == 9) ? sack : 1'b1);
                else slave_sda = 1'b1;
            end
            if (!pscl && bus.scl_o) begin
                rise++;
                cap = {cap[7:0], bus.sda_i};
                if (rd && rise == sbit + 1) stl = 10;
            end
            if (!psda && bus.sda_o && bus.scl_o) rise_hi = 1;
            if (psda && !bus.sda_o && bus.scl_o) fall_hi = 1;
            stretch = stl > 0;
            if (stl > 0) stl--;
            pscl = bus.scl_o; psda = bus.sda_o;
            if (fall == abort_fall) begin
                #2 rst_n = 1'b0;
                #1 check_reset_outputs("rst_mid");
                repeat (2) @(negedge clk);
                check_reset_outputs("rst_hold");
                rst_n = 1'b1; m_busy = 0; slave_sda = 1'b1; stretch = 1'b0;
                aborted = 1;
                break;
            end
            if (bus.rsp_valid_o) break;
        end
        if (!aborted) begin
            nb = m_busy;
            k = -1;
            if (!legal) lat = 2;
            else if (cmd == 3'd1) begin
                for (int i = 7; i >= 0; i--) if (k < 0 && d[i] && !cont[i]) k = 7 - i;
                lat = (k >= 0) ? 4 * p * k + 3 * p + 1 : 36 * p + 1;
            end else if (cmd == 3'd2) lat = 36 * p + 1 + ((sbit >= 0) ? 10 : 0);
            else lat = 4 * p + 1;
            if (legal && cmd == 3'd0) nb = 1;
            if (legal && cmd == 3'd3) nb = 0;
            if (k >= 0) nb = 0;
            check("latency", n, lat);
            check("rsp_valid", bus.rsp_valid_o, 1);
            check("err", bus.rsp_err_o, (!legal || k >= 0) ? 1 : 0);
            check("ready_done", bus.cmd_ready_o, 1);
            check("ready_low", rdy_bad, 0);
            check("busy", bus.busy_o, nb);
            if (!legal) check("quiet", quiet, 1);
            else if (wr && k >= 0) check("arb_lines", {bus.scl_o, bus.sda_o}, 2'b11);
            else if (wr) begin
                check("wbyte", cap[8:1], d);
                check("wack", bus.rsp_ack_o, sack);
                check("wglitch", {rise_hi, fall_hi}, 0);
            end else if (rd) begin
                check("rdata", bus.rsp_data_o, rbyte);
                check("mack", cap[0], ack);
                check("rglitch", {rise_hi, fall_hi}, 0);
            end else if (cmd == 3'd3) begin
                check("stop_cond", rise_hi, 1);
                check("stop_lines", {bus.scl_o, bus.sda_o}, 2'b11);
            end else begin
                check("start_cond", fall_hi, 1);
                check("start_lines", {bus.scl_o, bus.sda_o}, 2'b10);
            end
            if (bus.rsp_err_o) slave_sda = 1'b1;
            m_busy = nb;
        end
    endtask

    initial begin
        int c;
        logic [2:0] cmd;
        bus.cmd_valid_i = 1'b0; bus.cmd_i = '0; bus.cmd_data_i = '0; bus.cmd_ack_i = 1'b0; bus.prescaler_i = 8'd1;
        #12 check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        do_cmd(3'd1, 8'h5A, 1'b0, 8'd2, 8'h00, 8'hFF, 1'b0, -1, -1);
        do_cmd(3'd0, 8'h00, 1'b0, 8'd2, 8'h00, 8'hFF, 1'b0, -1, -1);
        do_cmd(3'd1, 8'hA4, 1'b0, 8'd2, 8'h00, 8'hFF, 1'b0, -1, -1);
        do_cmd(3'd2, 8'h00, 1'b1, 8'd2, 8'h5B, 8'hFF, 1'b0, -1, -1);
        do_cmd(3'd3, 8'h00, 1'b0, 8'd2, 8'h00, 8'hFF, 1'b0, -1, -1);
        do_cmd(3'd0, 8'h00, 1'b0, 8'd2, 8'h00, 8'hFF, 1'b0, -1, -1);
        do_cmd(3'd1, 8'hFF, 1'b0, 8'd2, 8'h00, 8'h7F, 1'b0, -1, -1);
        do_cmd(3'd0, 8'h00, 1'b0, 8'd0, 8'h00, 8'hFF, 1'b0, -1, -1);
        do_cmd(3'd2, 8'h00, 1'b0, 8'd3, 8'hC3, 8'hFF, 1'b0, 3, -1);
        do_cmd(3'd0, 8'h00, 1'b0, 8'd1, 8'h00, 8'hFF, 1'b0, -1, -1);
        do_cmd(3'd2, 8'h00, 1'b0, 8'd2, 8'h96, 8'hFF, 1'b0, -1, 6);
        do_cmd(3'd0, 8'h00, 1'b0, 8'd2, 8'h00, 8'hFF, 1'b0, -1, -1);
        do_cmd(3'd7, 8'h00, 1'b0, 8'd1, 8'h00, 8'hFF, 1'b0, -1, -1);
        repeat (80) begin
            c = $urandom_range(0, 9);
            cmd = (c < 2) ? 3'd0 : (c < 5) ? 3'd1 : (c < 7) ? 3'd2 : (c == 7) ? 3'd3 : (c == 8) ? 3'd4 : 3'($urandom_range(5, 7));
            do_cmd(cmd, 8'($urandom), 1'($urandom), 8'($urandom_range(0, 3)), 8'($urandom),
                   ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1, -1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
